lse_div_pipe: RTL and testbench

LSE_DIV_PIPE -- requirements
Module: lse_div_pipe

---
 rtl/lse_div_pipe.sv | 123 ++++++++++++
 tb/tb_lse_div_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lse_div_pipe.sv
// lse_div_pipe: two-stage elastic log-domain divider, log(a/b) = log(a) - log(b).
// Build option: define LSE_DIV_SAT_EN to saturate signed overflow of a - b
// instead of wrapping modulo 2^WIDTH.
module lse_div_pipe #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic [1:0]       i_pe_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_zero,
    output logic             o_mode_err,
    output logic [15:0]      o_op_count
);
    localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_FIN = NEG_INF + 1'b1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_inf;
    logic             r_b_inf;
    logic             r_s1_mode_err;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_div_zero;
    logic             r_mode_err;
    logic [15:0]      r_op_count;

    logic             w_s2_free;
    logic             w_xfer_in;
    logic             w_s2_load;
    logic             w_xfer_out;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_finite;
    logic [WIDTH-1:0] w_result;

    // Stage 2 can take a new entry when it is empty or being drained this cycle.
    assign w_s2_free  = !r_s2_valid || i_ready;
    assign o_ready    = !r_s1_valid || w_s2_free;
    assign w_xfer_in  = i_valid && o_ready;
    assign w_s2_load  = r_s1_valid && w_s2_free;
    assign w_xfer_out = r_s2_valid && i_ready;

    assign w_diff = r_a - r_b;
`ifdef LSE_DIV_SAT_EN
    logic w_ovf;
    // Overflow only when operand signs differ and the difference flips away from a's sign.
    assign w_ovf    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
    // A finite quotient is clamped so it never collides with the NEG_INF code.
    assign w_finite = w_ovf ? (r_a[WIDTH-1] ? MIN_FIN : MAX_POS)
                            : ((w_diff == NEG_INF) ? MIN_FIN : w_diff);
`else
    assign w_finite = w_diff;
`endif

    assign w_result = r_s1_mode_err        ? NEG_INF :
                      (r_a_inf && r_b_inf) ? NEG_INF :
                      r_b_inf              ? MAX_POS :
                      r_a_inf              ? NEG_INF : w_finite;

    // Stage 1: capture operands and classify them on every accepted pair.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid    <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_a_inf       <= 1'b0;
            r_b_inf       <= 1'b0;
            r_s1_mode_err <= 1'b0;
        end else begin
            if (w_xfer_in) begin
                r_s1_valid    <= 1'b1;
                r_a           <= i_operand_a;
                r_b           <= i_operand_b;
                r_a_inf       <= (i_operand_a == NEG_INF);
                r_b_inf       <= (i_operand_b == NEG_INF);
                r_s1_mode_err <= (i_pe_mode != 2'b00);
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: register result and flags; hold them while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
            r_mode_err <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= w_result;
                r_div_zero <= !r_s1_mode_err && r_b_inf;
                r_mode_err <= r_s1_mode_err;
            end
        end
    end

    // Count delivered results, wrapping naturally at 16 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_count <= '0;
        end else if (w_xfer_out) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign o_valid    = r_s2_valid;
    assign o_result   = r_result;
    assign o_div_zero = r_div_zero;
    assign o_mode_err = r_mode_err;
    assign o_op_count = r_op_count;
endmodule

// File: tb/tb_lse_div_pipe.sv
// tb_lse_div_pipe: directed self-checking bench for lse_div_pipe.
// Honours LSE_DIV_SAT_EN for the overflow expectations.
module tb_lse_div_pipe;
    localparam int W = 24;

    logic         clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_operand_a;
    logic [W-1:0] i_operand_b;
    logic [1:0]   i_pe_mode;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_div_zero;
    logic         o_mode_err;
    logic [15:0]  o_op_count;

    int tests = 0;
    int fails = 0;

    lse_div_pipe #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_pe_mode(i_pe_mode),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_div_zero(o_div_zero), .o_mode_err(o_mode_err), .o_op_count(o_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] op_a(input int i);
        return W'(300000 + 1111 * i);
    endfunction

    function automatic logic [W-1:0] op_b(input int i);
        return W'(100000 - 77 * i);
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0;
        #7;
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] mode, input logic [W-1:0] er,
                          input logic edz, input logic eme);
        i_ready     = 1'b1;
        i_valid     = 1'b1;
        i_operand_a = a;
        i_operand_b = b;
        i_pe_mode   = mode;
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_pe_mode = 2'b00;
        @(negedge clk);
        check({tag, "_lat1"}, o_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_res"}, o_result, er);
        check({tag, "_dz"}, o_div_zero, edz);
        check({tag, "_me"}, o_mode_err, eme);
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input string tag, input int n, input int stall);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic [W-1:0] held = '0;
        while (got < n && cyc < 200) begin
            i_valid     = (sent < n);
            i_operand_a = op_a(sent);
            i_operand_b = op_b(sent);
            i_pe_mode   = 2'b00;
            i_ready     = (cyc >= stall);
            @(negedge clk);
            if (cyc >= 2 && cyc < stall) check({tag, "_bp_ready"}, o_ready, 0);
            if (cyc >= 3 && cyc < stall) check({tag, "_bp_hold"}, o_result, held);
            if (o_valid) held = o_result;
            if (o_valid && i_ready) begin
                check({tag, "_res"}, o_result, op_a(got) - op_b(got));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (i_valid && o_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        i_valid = 1'b0;
        check({tag, "_count_got"}, got, n);
        check({tag, "_op_count"}, o_op_count, n);
        if (stall == 0) check({tag, "_no_bubble"}, last - first, n - 1);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        i_operand_a = '0;
        i_operand_b = '0;
        i_pe_mode   = 2'b00;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_dz", o_div_zero, 0);
        check("rst_me", o_mode_err, 0);
        check("rst_cnt", o_op_count, 0);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1);

        single("basic", 24'd300000, 24'd100000, 2'b00, 24'd200000, 1'b0, 1'b0);
        single("a_inf", 24'h800000, 24'h123456, 2'b00, 24'h800000, 1'b0, 1'b0);
        single("b_inf", 24'h123456, 24'h800000, 2'b00, 24'h7FFFFF, 1'b1, 1'b0);
        single("ab_inf", 24'h800000, 24'h800000, 2'b00, 24'h800000, 1'b1, 1'b0);
        single("mode", 24'h001000, 24'h000010, 2'b01, 24'h800000, 1'b0, 1'b1);
        single("neg", 24'h000010, 24'h000020, 2'b00, 24'hFFFFF0, 1'b0, 1'b0);
`ifdef LSE_DIV_SAT_EN
        single("ovf_pos", 24'h7FFFFF, 24'hFFFFFF, 2'b00, 24'h7FFFFF, 1'b0, 1'b0);
        single("ovf_neg", 24'h800001, 24'h000002, 2'b00, 24'h800001, 1'b0, 1'b0);
        single("near_inf", 24'h800001, 24'h000001, 2'b00, 24'h800001, 1'b0, 1'b0);
`else
        single("ovf_pos", 24'h7FFFFF, 24'hFFFFFF, 2'b00, 24'h800000, 1'b0, 1'b0);
        single("ovf_neg", 24'h800001, 24'h000002, 2'b00, 24'h7FFFFF, 1'b0, 1'b0);
        single("near_inf", 24'h800001, 24'h000001, 2'b00, 24'h800000, 1'b0, 1'b0);
`endif
        check("cnt_after_singles", o_op_count, 9);

        do_reset();
        stream("bp", 4, 5);
        do_reset();
        stream("thru", 20, 0);

        do_reset();
        single("pre_rst", 24'd5000, 24'd1000, 2'b00, 24'd4000, 1'b0, 1'b0);
        i_ready     = 1'b0;
        i_valid     = 1'b1;
        i_operand_a = 24'd777;
        i_operand_b = 24'd7;
        @(posedge clk);
        #1;
        i_operand_a = 24'd888;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("mid_inflight", o_valid, 1);
        check("mid_cnt_before", o_op_count, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_cnt", o_op_count, 0);
        check("mid_rst_result", o_result, 0);
        @(posedge clk);
        #2;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", o_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_no_stale", o_valid, 0);
        end
        check("mid_cnt_after", o_op_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
